keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/keypad_repeat_timer.sv | 51 +++++
 rtl/keypad_scan_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// =====================================================================
// Module   : keypad_pkg
// Purpose  : Scan FSM state type and the alarm-clock key-code map.
// Revision : 1.0 - initial release
// =====================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } key_state_t;

  localparam logic [3:0] c_CODE_AMPM   = 4'b1010;
  localparam logic [3:0] c_CODE_SET_TM = 4'b1011;
  localparam logic [3:0] c_CODE_SET_AL = 4'b1100;
  localparam logic [3:0] c_CODE_UNUSED = 4'b1111;

  // Layout: 1 2 3 AM/PM / 4 5 6 SetTime / 7 8 9 SetAlarm / - 0 - -
  function automatic logic [3:0] key_code(input logic [3:0] idx);
    case (idx)
      4'd0:    key_code = 4'd1;
      4'd1:    key_code = 4'd2;
      4'd2:    key_code = 4'd3;
      4'd3:    key_code = c_CODE_AMPM;
      4'd4:    key_code = 4'd4;
      4'd5:    key_code = 4'd5;
      4'd6:    key_code = 4'd6;
      4'd7:    key_code = c_CODE_SET_TM;
      4'd8:    key_code = 4'd7;
      4'd9:    key_code = 4'd8;
      4'd10:   key_code = 4'd9;
      4'd11:   key_code = c_CODE_SET_AL;
      4'd13:   key_code = 4'd0;
      default: key_code = c_CODE_UNUSED;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_repeat_timer.sv
`default_nettype none
// =====================================================================
// Module   : keypad_repeat_timer
// Purpose  : Auto-repeat tick generator: first tick REPEAT_DELAY cycles
//            after start, then every REPEAT_RATE cycles while run is high.
// Revision : 1.0 - initial release
// =====================================================================
module keypad_repeat_timer
  import keypad_pkg::*;
#(
  parameter int REPEAT_DELAY = 128,
  parameter int REPEAT_RATE  = 32
) (
  input  logic clk_256Hz,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic tick
);

  localparam int c_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_TW  = $clog2(c_MAX + 1);
  localparam logic [c_TW-1:0] c_DELAY_LAST = c_TW'(REPEAT_DELAY - 1);
  localparam logic [c_TW-1:0] c_RATE_LAST  = c_TW'(REPEAT_RATE - 1);
  localparam logic [c_TW-1:0] c_SAT        = c_TW'(c_MAX);
  localparam logic [c_TW-1:0] c_ONE        = c_TW'(1);

  logic [c_TW-1:0] r_cnt;
  logic            r_rate_phase;
  logic [c_TW-1:0] w_last;

  assign w_last = r_rate_phase ? c_RATE_LAST : c_DELAY_LAST;
  assign tick   = run && (r_cnt == w_last);

  always_ff @(posedge clk_256Hz or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_rate_phase <= 1'b0;
    end else if (start) begin
      r_cnt        <= '0;
      r_rate_phase <= 1'b0;
    end else if (tick) begin
      r_cnt        <= '0;
      r_rate_phase <= 1'b1;
    end else if (run && (r_cnt != c_SAT)) begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// =====================================================================
// Module   : keypad_scan_ctrl
// Purpose  : Row-scanning matrix keypad controller with debounce,
//            multi-key rejection and auto-repeat.
// Revision : 1.0 - initial release
// =====================================================================
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int N_ROWS       = 4,
  parameter int N_COLS       = 4,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 128,
  parameter int REPEAT_RATE  = 32
) (
  input  logic                              clk_256Hz,
  input  logic                              reset,
  input  logic [N_COLS-1:0]                 col,
  output logic [N_ROWS-1:0]                 row,
  output logic [$clog2(N_ROWS*N_COLS)-1:0]  key_index,
  output logic                              key_valid,
  output logic                              key_repeat,
  output logic                              key_held,
  output logic                              key_release,
  output logic                              key_err
);

  localparam int c_KW = $clog2(N_ROWS*N_COLS);
  localparam int c_DW = $clog2(DEBOUNCE + 1);
  localparam logic [c_DW-1:0]   c_CNT_LAST = c_DW'(DEBOUNCE - 1);
  localparam logic [c_DW-1:0]   c_CNT_ONE  = c_DW'(1);
  localparam logic [N_COLS-1:0] c_COL_ONE  = N_COLS'(1);
  localparam logic [N_ROWS-1:0] c_ROW_INIT = N_ROWS'(1);
  localparam logic              c_FAST     = (DEBOUNCE == 1);

  key_state_t        r_state, w_state_next;
  logic [N_ROWS-1:0] r_row, w_row_next;
  logic [N_COLS-1:0] r_col_lat;
  logic [c_DW-1:0]   r_cnt, w_cnt_next;
  logic [c_KW-1:0]   r_key_index, w_index;
  logic              r_key_valid, r_key_repeat, r_key_held, r_key_release, r_key_err;
  logic              w_latch, w_accept, w_release, w_err, w_repeat, w_tick;
  logic              w_col_zero, w_multi, w_one_hot, w_match, w_cnt_last;
  int                w_row_pos, w_col_pos;

  assign w_col_zero = (col == '0);
  assign w_multi    = ((col & (col - c_COL_ONE)) != '0);
  assign w_one_hot  = !w_col_zero && !w_multi;
  assign w_match    = (col == r_col_lat);
  assign w_cnt_last = (r_cnt == c_CNT_LAST);

  // Row is frozen outside SCAN, so the live row/col give the key position.
  always_comb begin
    w_row_pos = 0;
    w_col_pos = 0;
    for (int i = 0; i < N_ROWS; i++) if (r_row[i]) w_row_pos = N_ROWS - 1 - i;
    for (int j = 0; j < N_COLS; j++) if (col[j])   w_col_pos = N_COLS - 1 - j;
    w_index = c_KW'(w_row_pos * N_COLS + w_col_pos);
  end

  always_ff @(posedge clk_256Hz or posedge reset) begin
    if (reset) r_state <= ST_SCAN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_row_next   = r_row;
    w_cnt_next   = r_cnt;
    w_latch      = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (w_col_zero) begin
          w_row_next = {r_row[0], r_row[N_ROWS-1:1]};
        end else if (w_one_hot) begin
          w_latch      = 1'b1;
          w_state_next = c_FAST ? ST_PRESSED : ST_DEBOUNCE;
          w_cnt_next   = c_FAST ? '0 : c_CNT_ONE;
        end else begin
          w_state_next = ST_RELEASE;
          w_cnt_next   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!w_match) begin
          w_state_next = ST_SCAN;
          w_cnt_next   = '0;
        end else if (w_cnt_last) begin
          w_state_next = ST_PRESSED;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + c_CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (w_match) begin
          w_cnt_next = '0;
        end else if (w_cnt_last) begin
          w_state_next = ST_SCAN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        if (!w_col_zero) begin
          w_cnt_next = '0;
        end else if (w_cnt_last) begin
          w_state_next = ST_SCAN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + c_CNT_ONE;
        end
      end
    endcase
  end

  // Release wins over a coincident repeat tick so pulses stay exclusive.
  always_comb begin
    w_accept  = 1'b0;
    w_release = 1'b0;
    w_err     = 1'b0;
    w_repeat  = 1'b0;
    case (r_state)
      ST_SCAN: begin
        w_accept = c_FAST && w_one_hot;
        w_err    = w_multi;
      end
      ST_DEBOUNCE: w_accept = w_match && w_cnt_last;
      ST_PRESSED: begin
        w_release = !w_match && w_cnt_last;
        w_repeat  = w_tick && !w_release;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_256Hz or posedge reset) begin
    if (reset) begin
      r_row         <= c_ROW_INIT;
      r_col_lat     <= '0;
      r_cnt         <= '0;
      r_key_index   <= '0;
      r_key_valid   <= 1'b0;
      r_key_repeat  <= 1'b0;
      r_key_held    <= 1'b0;
      r_key_release <= 1'b0;
      r_key_err     <= 1'b0;
    end else begin
      r_row         <= w_row_next;
      r_cnt         <= w_cnt_next;
      if (w_latch)  r_col_lat   <= col;
      if (w_accept) r_key_index <= w_index;
      r_key_valid   <= w_accept | w_repeat;
      r_key_repeat  <= w_repeat;
      r_key_held    <= (r_key_held | w_accept) & ~w_release;
      r_key_release <= w_release;
      r_key_err     <= w_err;
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_repeat
      keypad_repeat_timer #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
      ) u_timer (
        .clk_256Hz (clk_256Hz),
        .reset     (reset),
        .start     (w_accept),
        .run       (r_state == ST_PRESSED),
        .tick      (w_tick)
      );
    end else begin : g_no_repeat
      assign w_tick = 1'b0;
    end
  endgenerate

  assign row         = r_row;
  assign key_index   = r_key_index;
  assign key_valid   = r_key_valid;
  assign key_repeat  = r_key_repeat;
  assign key_held    = r_key_held;
  assign key_release = r_key_release;
  assign key_err     = r_key_err;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// =====================================================================
// Module   : tb_keypad_scan_ctrl
// Purpose  : Directed self-checking bench for keypad_scan_ctrl (4x4).
// Revision : 1.0 - initial release
// =====================================================================
module tb_keypad_scan_ctrl;

  logic       clk_256Hz = 1'b0;
  logic       reset     = 1'b0;
  logic [3:0] col       = 4'b0000;
  logic [3:0] row;
  logic [3:0] key_index;
  logic       key_valid, key_repeat, key_held, key_release, key_err;
  int         checks = 0;
  int         errors = 0;

  always #5 clk_256Hz = ~clk_256Hz;

  keypad_scan_ctrl #(
    .N_ROWS(4), .N_COLS(4), .DEBOUNCE(4), .REPEAT_EN(1),
    .REPEAT_DELAY(128), .REPEAT_RATE(32)
  ) dut (
    .clk_256Hz   (clk_256Hz),
    .reset       (reset),
    .col         (col),
    .row         (row),
    .key_index   (key_index),
    .key_valid   (key_valid),
    .key_repeat  (key_repeat),
    .key_held    (key_held),
    .key_release (key_release),
    .key_err     (key_err)
  );

  task automatic step();
    @(posedge clk_256Hz);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    col   = 4'b0000;
    #1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    #1 reset = 1'b1;
    #1;
    checks++; if (row !== 4'b0001) begin errors++; $display("FAIL reset_row: got %b expected 0001", row); end
    checks++; if ({key_valid, key_repeat, key_held, key_release, key_err} !== 5'b00000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 00000", {key_valid, key_repeat, key_held, key_release, key_err}); end
    checks++; if (key_index !== 4'd0) begin errors++; $display("FAIL reset_index: got %0d expected 0", key_index); end
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      exp_row = 4'b1000 >> (i % 4);
      checks++; if (row !== exp_row) begin errors++; $display("FAIL rotate_%0d: got %b expected %b", i, row, exp_row); end
    end
  endtask

  task automatic test_keys();
    int         t_n   [4];
    logic [3:0] t_col [4];
    logic [3:0] t_idx [4];
    int         early;
    int         rel_early;
    t_n   = '{1, 3, 4, 2};
    t_col = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};
    t_idx = '{4'd1, 4'd11, 4'd12, 4'd6};
    for (int e = 0; e < 4; e++) begin
      do_reset();
      repeat (t_n[e]) step();
      col   = t_col[e];
      early = 0;
      for (int s = 0; s < 3; s++) begin step(); if (key_valid) early++; end
      checks++; if (early !== 0) begin errors++; $display("FAIL key%0d_early: got %0d valid pulses expected 0", e, early); end
      step();
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL key%0d_valid: got %b expected 1", e, key_valid); end
      checks++; if (key_index !== t_idx[e]) begin errors++; $display("FAIL key%0d_index: got %0d expected %0d", e, key_index, t_idx[e]); end
      checks++; if ({key_held, key_repeat} !== 2'b10) begin errors++; $display("FAIL key%0d_held_rep: got %b expected 10", e, {key_held, key_repeat}); end
      step();
      checks++; if ({key_valid, key_held} !== 2'b01) begin errors++; $display("FAIL key%0d_pulse: got %b expected 01", e, {key_valid, key_held}); end
      col       = 4'b0000;
      rel_early = 0;
      for (int s = 0; s < 3; s++) begin step(); if (key_release) rel_early++; end
      step();
      checks++; if ({rel_early[0], key_release, key_held} !== 3'b010) begin
        errors++; $display("FAIL key%0d_release: got early=%0d rel=%b held=%b expected 0,1,0", e, rel_early, key_release, key_held); end
      step();
      checks++; if (key_release !== 1'b0) begin errors++; $display("FAIL key%0d_rel_pulse: got %b expected 0", e, key_release); end
    end
  endtask

  task automatic test_bounce();
    int seen;
    seen = 0;
    do_reset();
    step();
    col = 4'b0100;
    step(); seen += int'(key_valid);
    step(); seen += int'(key_valid);
    col = 4'b0000;
    step(); seen += int'(key_valid);
    checks++; if (row !== 4'b1000) begin errors++; $display("FAIL bounce_row_hold: got %b expected 1000", row); end
    step(); seen += int'(key_valid);
    checks++; if (row !== 4'b0100) begin errors++; $display("FAIL bounce_row_resume: got %b expected 0100", row); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL bounce_valid: got %0d pulses expected 0", seen); end
  endtask

  task automatic test_multi();
    int extra;
    int vseen;
    extra = 0;
    vseen = 0;
    do_reset();
    step();
    col = 4'b1010;
    step();
    checks++; if ({key_err, key_valid, row} !== 6'b10_1000) begin
      errors++; $display("FAIL multi_err: got err=%b valid=%b row=%b expected 1,0,1000", key_err, key_valid, row); end
    step(); extra += int'(key_err); vseen += int'(key_valid);
    step(); extra += int'(key_err); vseen += int'(key_valid);
    col = 4'b0000;
    for (int i = 1; i <= 5; i++) begin
      step(); extra += int'(key_err); vseen += int'(key_valid);
      if (i == 4) begin
        checks++; if (row !== 4'b1000) begin errors++; $display("FAIL multi_frozen: got %b expected 1000", row); end
      end
    end
    checks++; if (row !== 4'b0100) begin errors++; $display("FAIL multi_resume: got %b expected 0100", row); end
    checks++; if ({extra, vseen} !== {32'd0, 32'd0}) begin
      errors++; $display("FAIL multi_pulses: got err=%0d valid=%0d expected 0,0", extra, vseen); end
  endtask

  task automatic test_repeat();
    int   n_valid, rel_cyc, overlap;
    int   v_cyc [4];
    logic v_rep [4];
    bit   got;
    got = 1'b0;
    do_reset();
    step();
    col = 4'b0100;
    for (int i = 0; i < 8 && !got; i++) begin step(); if (key_valid) got = 1'b1; end
    checks++;
    if (!got) begin
      errors++; $display("FAIL repeat_accept: got no key_valid in 8 cycles expected one");
    end else begin
      n_valid = 1; rel_cyc = -1; overlap = 0;
      v_cyc = '{0, -1, -1, -1};
      v_rep = '{key_repeat, 1'b0, 1'b0, 1'b0};
      for (int k = 1; k <= 210; k++) begin
        col = (k < 200) ? 4'b0100 : 4'b0000;
        step();
        if (key_valid) begin
          if (n_valid < 4) begin v_cyc[n_valid] = k; v_rep[n_valid] = key_repeat; end
          n_valid++;
        end
        if (key_release && rel_cyc < 0) rel_cyc = k;
        if (key_valid && key_release) overlap++;
      end
      checks++; if (n_valid !== 4) begin errors++; $display("FAIL repeat_count: got %0d expected 4", n_valid); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (v_cyc[i] !== ((i == 0) ? 0 : 96 + 32*i)) begin
          errors++; $display("FAIL repeat_time_%0d: got %0d expected %0d", i, v_cyc[i], (i == 0) ? 0 : 96 + 32*i); end
        checks++; if (v_rep[i] !== (i != 0)) begin
          errors++; $display("FAIL repeat_flag_%0d: got %b expected %b", i, v_rep[i], (i != 0)); end
      end
      checks++; if (rel_cyc !== 203) begin errors++; $display("FAIL repeat_release: got %0d expected 203", rel_cyc); end
      checks++; if (overlap !== 0) begin errors++; $display("FAIL repeat_overlap: got %0d expected 0", overlap); end
      checks++; if (key_index !== 4'd1) begin errors++; $display("FAIL repeat_index: got %0d expected 1", key_index); end
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    int rel_seen;
    got = 1'b0;
    rel_seen = 0;
    do_reset();
    step();
    col = 4'b0100;
    for (int i = 0; i < 8 && !got; i++) begin step(); if (key_valid) got = 1'b1; end
    checks++;
    if (!got) begin
      errors++; $display("FAIL midrst_accept: got no key_valid in 8 cycles expected one");
    end else begin
      repeat (50) step();
      #3 reset = 1'b1;
      #1;
      checks++; if ({key_held, key_release, key_valid, row} !== 7'b000_0001) begin
        errors++; $display("FAIL midrst_state: got held=%b rel=%b valid=%b row=%b expected 0,0,0,0001",
                           key_held, key_release, key_valid, row); end
      step();
      reset = 1'b0;
      col   = 4'b0000;
      repeat (8) begin step(); rel_seen += int'(key_release); end
      checks++; if (rel_seen !== 0) begin errors++; $display("FAIL midrst_release: got %0d pulses expected 0", rel_seen); end
    end
  endtask

  initial begin
    test_reset();
    test_keys();
    test_bounce();
    test_multi();
    test_repeat();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
